// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: scoreboards in-flight load/long-op destinations,
// detects RAW/WAW/structural hazards and sequences redirect flushes.
module id_hazard_ctrl #(
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_writes_rd,
    input  logic             id_is_load,
    input  logic             id_is_long,
    input  logic             long_done,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             ex_redirect,
    output logic             issue,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned NREG = 32;
    localparam int unsigned FC_W = 3;

    if (FLUSH_LEN < 1 || FLUSH_LEN > 4) begin : g_bad_flush_len
        $error("FLUSH_LEN must be in 1..4");
    end

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [FC_W-1:0]   cnt, cnt_nxt;
    logic              long_busy, long_busy_nxt;
    logic [NREG-1:0]   pending_nxt;
    logic [CNT_W-1:0]  stall_count_nxt;

    logic [NREG-1:0]   clr_vec;
    logic [NREG-1:0]   set_vec;
    logic [NREG-1:0]   eff;
    logic              hazard;
    logic              flush_raw;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            cnt         <= '0;
            long_busy   <= 1'b0;
            pending     <= '0;
            stall_count <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            long_busy   <= long_busy_nxt;
            pending     <= pending_nxt;
            stall_count <= stall_count_nxt;
        end
    end

    // Hazard detection, control outputs and next-state logic
    always_comb begin
        clr_vec         = '0;
        set_vec         = '0;
        state_nxt       = state;
        cnt_nxt         = cnt;
        long_busy_nxt   = long_busy;
        stall_count_nxt = stall_count;

        if (wb_valid && wb_rd != 5'd0) begin
            clr_vec[wb_rd] = 1'b1;
        end
        // A same-cycle writeback releases its consumer without an extra cycle
        eff = pending & ~clr_vec;

        hazard = (id_uses_rs1  && eff[id_rs1])
              || (id_uses_rs2  && eff[id_rs2])
              || (id_writes_rd && eff[id_rd])
              || (id_is_long   && long_busy && !long_done);

        flush_raw = ex_redirect || (state == ST_FLUSH);

        // rst_n gating keeps the combinational controls quiet during reset
        flush  = rst_n && flush_raw;
        issue  = rst_n && id_valid && !hazard && !flush_raw;
        stall  = rst_n && id_valid &&  hazard && !flush_raw;
        bubble = stall || flush;

        case (state)
            ST_RUN: begin
                if (ex_redirect && FLUSH_LEN > 1) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = FC_W'(FLUSH_LEN - 1);
                end
            end
            ST_FLUSH: begin
                if (ex_redirect) begin
                    cnt_nxt = FC_W'(FLUSH_LEN - 1);
                end else if (cnt == FC_W'(1)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - FC_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase

        if (issue && id_writes_rd && (id_is_load || id_is_long) && id_rd != 5'd0) begin
            set_vec[id_rd] = 1'b1;
        end
        // Set is applied after clear so an issuing writer wins a collision
        pending_nxt    = (pending & ~clr_vec) | set_vec;
        pending_nxt[0] = 1'b0;

        if (issue && id_is_long) begin
            long_busy_nxt = 1'b1;
        end else if (long_done) begin
            long_busy_nxt = 1'b0;
        end

        if (stall) begin
            stall_count_nxt = stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Scoreboard-based hazard and sequencing controller for the ID stage of the pipelined core.
- Consumes decoded register fields (rs1, rs2, rd) plus per-instruction control flags.
- Tracks destination registers of in-flight loads and long-latency ops (mul/div).
- Drives issue, stall, bubble and flush controls for the PC, IF/ID and ID/EX registers.

Parameters:
- FLUSH_LEN, 2, total cycles flush is asserted per redirect, counting the redirect cycle; legal range 1..4.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a valid instruction.
- id_rs1  input  5  source register 1 field.
- id_rs2  input  5  source register 2 field.
- id_rd  input  5  destination register field.
- id_uses_rs1  input  1  instruction reads rs1.
- id_uses_rs2  input  1  instruction reads rs2.
- id_writes_rd  input  1  instruction writes rd.
- id_is_load  input  1  instruction is a load.
- id_is_long  input  1  instruction uses the multi-cycle unit.
- long_done  input  1  multi-cycle unit finished; frees the unit.
- wb_valid  input  1  writeback of a scoreboarded result this cycle.
- wb_rd  input  5  writeback destination.
- ex_redirect  input  1  EX resolved a taken branch or jump.
- issue  output  1  ID instruction advances into ID/EX this cycle.
- stall  output  1  hold PC and IF/ID.
- bubble  output  1  load NOP into ID/EX.
- flush  output  1  clear IF/ID.
- pending  output  32  scoreboard bit vector; bit 0 is always 0.
- stall_count  output  CNT_W  cycles in which stall was asserted.

Behaviour:
- Reset (async, rst_n=0): pending=0, long_busy=0, state=RUN, flush counter=0, stall_count=0. All outputs 0 while in reset.
- Reset mid-operation discards all scoreboard and FSM state immediately; no pending write survives.
- Effective pending: eff = pending & ~clr, where clr is the one-hot of wb_rd when wb_valid && wb_rd!=0. A same-cycle writeback therefore unblocks the consumer with no extra cycle.
- Register 0 is never set in pending and never causes a hazard.
- hazard, computed from eff, is the OR of:
  - RAW on rs1: id_uses_rs1 && eff[id_rs1]
  - RAW on rs2: id_uses_rs2 && eff[id_rs2]
  - WAW: id_writes_rd && eff[id_rd]
  - structural: id_is_long && long_busy && !long_done
- FSM states: RUN, FLUSH.
  - RUN: if ex_redirect, go to FLUSH with cnt=FLUSH_LEN-1; when FLUSH_LEN=1, stay in RUN.
  - FLUSH: decrement cnt each cycle; return to RUN when cnt reaches 1.
  - ex_redirect while in FLUSH reloads cnt=FLUSH_LEN-1.
- flush = ex_redirect || state==FLUSH.
- issue = id_valid && !hazard && !flush.
- stall = id_valid && hazard && !flush. Flush has priority over stall; a squashed instruction does not stall.
- bubble = stall || flush.
- Scoreboard update at the clock edge:
  - Clear bit wb_rd when wb_valid && wb_rd!=0.
  - Set bit id_rd when issue && id_writes_rd && (id_is_load||id_is_long) && id_rd!=0.
  - If set and clear hit the same register, set wins.
- long_busy: set on issue && id_is_long; cleared on long_done. Set wins over a same-cycle long_done.
- stall_count increments when stall=1 and wraps at 2^CNT_W.
- Combinational paths: the issue, stall, bubble and flush outputs are combinational from inputs plus registered state. Latency from hazard detection to stall is 0 cycles.

Test Plan:
- Load-use RAW:
  - Stimulus: issue load with rd=5; next cycle, id_valid with rs1=5, id_uses_rs1=1.
  - Required: stall=1, bubble=1, issue=0 each cycle until wb_valid with wb_rd=5.
  - Required: issue=1 in the writeback cycle itself (bypass); pending[5]=0 after that edge.
- x0 and unused source:
  - Stimulus: load with rd=0, then a consumer reading rs1=0; separately, rs2=7 pending but id_uses_rs2=0.
  - Required: pending stays 0 after the rd=0 load, and no stall in either case.
- Structural and WAW:
  - Stimulus: long op with rd=9 issued; second long op with rd=3 while long_busy. Separately, a load with rd=9 while pending[9]=1.
  - Required: long op stalls until long_done, issuing in the long_done cycle. The load with rd=9 stalls (WAW).
- Redirect during stall:
  - Stimulus: FLUSH_LEN=2; consumer stalled on pending[4]; assert ex_redirect for one cycle.
  - Required: flush=1 and bubble=1 for 2 cycles, stall=0, issue=0; pending[4] remains 1.
- Set/clear collision and reset:
  - Stimulus: same cycle, issue load rd=6 with wb_valid, wb_rd=6.
  - Required: pending[6]=1 after the edge.
  - Stimulus: then pulse rst_n low mid-stall.
  - Required: pending=0, stall_count=0, state RUN, all outputs 0 immediately.
- Counter:
  - Stimulus: hold a RAW hazard for 10 cycles.
  - Required: stall_count = 10.
